// File: rtl/param_seq_detector.sv
// param_seq_detector
//   Serial pattern detector with a run-time loadable LEN-bit pattern,
//   overlapping or non-overlapping matching, an input qualifier and a
//   saturating match counter.
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous active-high reset
//   in_i         serial data bit, used only when in_valid_i=1
//   in_valid_i   qualifies in_i; history and fill hold when low
//   pat_load_i   load pat_i into the pattern register (wins over in_valid_i)
//   pat_i        new pattern, MSB is the first bit in time
//   overlap_i    1: overlapping matches, 0: restart history after a match
//   cnt_clr_i    clear match_cnt_o (wins over a simultaneous hit)
//   detect_o     registered one-cycle match pulse
//   match_cnt_o  saturating match count
//   armed_o      history holds LEN valid bits
module param_seq_detector #(
  parameter int               LEN       = 4,
  parameter int               CNT_W     = 8,
  parameter logic [LEN-1:0]   RESET_PAT = LEN'(4'b1001)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_i,
  input  logic              in_valid_i,
  input  logic              pat_load_i,
  input  logic [LEN-1:0]    pat_i,
  input  logic              overlap_i,
  input  logic              cnt_clr_i,
  output logic              detect_o,
  output logic [CNT_W-1:0]  match_cnt_o,
  output logic              armed_o
);

  localparam int FW = $clog2(LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(LEN);

  logic [LEN-1:0]   pat_q, pat_d;
  logic [LEN-1:0]   hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             det_q, det_d;
  logic             armed_q, armed_d;

  logic [LEN-1:0]   nh;
  logic [FW-1:0]    nf;
  logic             hit;

  always_comb begin
    nh      = {hist_q[LEN-2:0], in_i};
    nf      = (fill_q == FULL) ? FULL : fill_q + FW'(1);
    // A load cycle never matches: the incoming bit is dropped.
    hit     = in_valid_i && !pat_load_i && (nf == FULL) && (nh == pat_q);

    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    det_d   = 1'b0;
    cnt_d   = cnt_q;

    if (pat_load_i) begin
      pat_d  = pat_i;
      fill_d = '0;
    end else if (in_valid_i) begin
      hist_d = nh;
      det_d  = hit;
      // Non-overlap mode demands LEN fresh bits before the next match.
      fill_d = (hit && !overlap_i) ? '0 : nf;
    end

    if (cnt_clr_i)
      cnt_d = '0;
    else if (hit && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);

    armed_d = (fill_d == FULL);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pat_q   <= RESET_PAT;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      det_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      det_q   <= det_d;
      armed_q <= armed_d;
    end
  end

  assign detect_o    = det_q;
  assign match_cnt_o = cnt_q;
  assign armed_o     = armed_q;

endmodule
